// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - sample FIFO with a registered output stage feeding an interleaved-stream consumer
//
// Purpose:
//   Buffers producer samples in a DEPTH-entry circular FIFO and offers them to a
//   consumer through a one-entry output register (ack/data_out). Each accepted
//   sample is tagged with a stream index that cycles through NR_STREAMS slots.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - asynchronous active-low reset
//   flush        - synchronous clear of FIFO and output stage
//   wr_en        - producer write strobe
//   wr_data      - producer sample
//   full         - FIFO (excluding output stage) holds DEPTH entries
//   req          - consumer request; transfer when req && ack at an edge
//   ack          - data_out holds a valid sample
//   data_out     - sample offered to consumer
//   stream_idx   - stream index of the sample on data_out
//   level        - FIFO entries plus the output stage occupancy
//   underrun_cnt - saturating count of edges with req=1 and ack=0
//   overflow     - sticky flag: a write was dropped because the FIFO was full
module sample_feeder #(
  parameter int DWIDTH         = 16,
  parameter int DEPTH          = 32,
  parameter int DEPTH_LOG      = 5,
  parameter int NR_STREAMS     = 16,
  parameter int NR_STREAMS_LOG = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [DWIDTH-1:0]         wr_data,
  output logic                      full,
  input  logic                      req,
  output logic                      ack,
  output logic [DWIDTH-1:0]         data_out,
  output logic [NR_STREAMS_LOG-1:0] stream_idx,
  output logic [DEPTH_LOG:0]        level,
  output logic [15:0]               underrun_cnt,
  output logic                      overflow
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } state_t;

  localparam logic [DEPTH_LOG:0]        CNT_ONE  = 1;
  localparam logic [DEPTH_LOG:0]        CNT_FULL = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG-1:0]      PTR_ONE  = 1;
  localparam logic [NR_STREAMS_LOG-1:0] SIDX_ONE = 1;
  localparam logic [NR_STREAMS_LOG-1:0] SIDX_MAX = NR_STREAMS_LOG'(NR_STREAMS - 1);

  state_t                state_q, state_d;
  logic [DWIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH_LOG:0]    count, count_d;
  logic                  do_write, do_pop, xfer;

  assign ack = (state_q == S_VALID);

  // Next-state and datapath control. Flush overrides everything: no write,
  // no pop, output stage emptied.
  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    do_pop   = 1'b0;
    xfer     = 1'b0;
    count_d  = count;

    if (flush) begin
      state_d = S_EMPTY;
      count_d = '0;
    end else begin
      xfer     = req && (state_q == S_VALID);
      do_write = wr_en && !full;
      case (state_q)
        S_EMPTY: begin
          // Pop uses the pre-edge count, so a word written this edge cannot
          // bypass straight to the output.
          if (count != '0) begin
            do_pop  = 1'b1;
            state_d = S_VALID;
          end
        end
        S_VALID: begin
          if (xfer) begin
            if (count != '0) begin
              do_pop = 1'b1;
            end else begin
              state_d = S_EMPTY;
            end
          end
        end
        default: state_d = S_EMPTY;
      endcase

      case ({do_write, do_pop})
        2'b10:   count_d = count + CNT_ONE;
        2'b01:   count_d = count - CNT_ONE;
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage carries no reset; pointers and count make stale data invisible.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      level        <= '0;
      data_out     <= '0;
      stream_idx   <= '0;
      underrun_cnt <= '0;
      overflow     <= 1'b0;
    end else begin
      count <= count_d;
      full  <= (count_d == CNT_FULL);
      level <= count_d + (DEPTH_LOG+1)'(state_d == S_VALID);

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        stream_idx <= '0;
      end else begin
        if (do_write) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (do_pop) begin
          rd_ptr   <= rd_ptr + PTR_ONE;
          data_out <= mem[rd_ptr];
        end
        if (xfer) begin
          stream_idx <= (stream_idx == SIDX_MAX) ? '0 : stream_idx + SIDX_ONE;
        end
        if (wr_en && full) begin
          overflow <= 1'b1;
        end
      end

      if (req && !ack && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - directed self-checking bench for sample_feeder
module tb_sample_feeder;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        req;
  logic        ack;
  logic [15:0] data_out;
  logic [3:0]  stream_idx;
  logic [5:0]  level;
  logic [15:0] underrun_cnt;
  logic        overflow;

  int total;
  int bad;

  sample_feeder #(
    .DWIDTH(16), .DEPTH(32), .DEPTH_LOG(5), .NR_STREAMS(16), .NR_STREAMS_LOG(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .req(req), .ack(ack), .data_out(data_out),
    .stream_idx(stream_idx), .level(level), .underrun_cnt(underrun_cnt),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack act=%b exp=0", ack); end
    total++; if (data_out !== 16'h0) begin bad++; $display("FAIL reset_data act=%h exp=0000", data_out); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full act=%b exp=0", full); end
    total++; if (level !== 6'd0) begin bad++; $display("FAIL reset_level act=%0d exp=0", level); end
    total++; if (stream_idx !== 4'd0) begin bad++; $display("FAIL reset_sidx act=%0d exp=0", stream_idx); end
    total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL reset_underrun act=%0d exp=0", underrun_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow act=%b exp=0", overflow); end
  endtask

  task automatic test_single();
    do_reset();
    wr_en = 1'b1; wr_data = 16'h0001; req = 1'b1;
    tick();
    wr_en = 1'b0;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL single_no_bypass act=%b exp=0", ack); end
    total++; if (level !== 6'd1) begin bad++; $display("FAIL single_level_n act=%0d exp=1", level); end
    tick();
    total++; if ({ack, data_out, stream_idx} !== {1'b1, 16'h0001, 4'd0}) begin
      bad++; $display("FAIL single_valid act=%b/%h/%0d exp=1/0001/0", ack, data_out, stream_idx);
    end
    tick();
    req = 1'b0;
    total++; if ({ack, stream_idx, level} !== {1'b0, 4'd1, 6'd0}) begin
      bad++; $display("FAIL single_after_xfer act=%b/%0d/%0d exp=0/1/0", ack, stream_idx, level);
    end
    total++; if (data_out !== 16'h0001) begin bad++; $display("FAIL single_hold_data act=%h exp=0001", data_out); end
  endtask

  task automatic test_fill_and_drain();
    do_reset();
    for (int i = 0; i < 33; i++) begin
      wr_en = 1'b1; wr_data = 16'(i);
      tick();
    end
    total++; if ({full, level, overflow, ack} !== {1'b1, 6'd33, 1'b0, 1'b1}) begin
      bad++; $display("FAIL fill_33 act=full%b/lvl%0d/ovf%b/ack%b exp=1/33/0/1", full, level, overflow, ack);
    end
    wr_data = 16'h0099;
    tick();
    wr_en = 1'b0;
    total++; if ({full, level, overflow} !== {1'b1, 6'd33, 1'b1}) begin
      bad++; $display("FAIL fill_34_drop act=full%b/lvl%0d/ovf%b exp=1/33/1", full, level, overflow);
    end
    req = 1'b1;
    for (int k = 0; k < 33; k++) begin
      total++; if ({ack, data_out} !== {1'b1, 16'(k)}) begin
        bad++; $display("FAIL drain_%0d act=%b/%h exp=1/%h", k, ack, data_out, 16'(k));
      end
      tick();
    end
    req = 1'b0;
    total++; if ({ack, level, full} !== {1'b0, 6'd0, 1'b0}) begin
      bad++; $display("FAIL drain_end act=%b/%0d/%b exp=0/0/0", ack, level, full);
    end
  endtask

  task automatic test_back_to_back_streams();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 16'h0100 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      total++; if ({ack, data_out, stream_idx} !== {1'b1, 16'h0100 + 16'(i), 4'(i % 16)}) begin
        bad++; $display("FAIL stream_%0d act=%b/%h/%0d exp=1/%h/%0d", i, ack, data_out, stream_idx,
                        16'h0100 + 16'(i), i % 16);
      end
      tick();
    end
    req = 1'b0;
    total++; if ({ack, stream_idx} !== {1'b0, 4'd4}) begin
      bad++; $display("FAIL stream_end act=%b/%0d exp=0/4", ack, stream_idx);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    req = 1'b0;
    total++; if (underrun_cnt !== 16'd10) begin bad++; $display("FAIL underrun_10 act=%0d exp=10", underrun_cnt); end
    wr_en = 1'b1; wr_data = 16'h0055;
    tick();
    wr_en = 1'b0;
    tick();
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL underrun_ack act=%b exp=1", ack); end
    req = 1'b1;
    tick();
    req = 1'b0;
    total++; if ({underrun_cnt, ack} !== {16'd10, 1'b0}) begin
      bad++; $display("FAIL underrun_hold act=%0d/%b exp=10/0", underrun_cnt, ack);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = 16'h0200 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    total++; if ({ack, level, stream_idx, data_out} !== {1'b1, 6'd6, 4'd1, 16'h0201}) begin
      bad++; $display("FAIL flush_pre act=%b/%0d/%0d/%h exp=1/6/1/0201", ack, level, stream_idx, data_out);
    end
    flush = 1'b1; wr_en = 1'b1; wr_data = 16'hBEEF; req = 1'b1;
    tick();
    flush = 1'b0; wr_en = 1'b0; req = 1'b0;
    total++; if ({ack, level, stream_idx, full} !== {1'b0, 6'd0, 4'd0, 1'b0}) begin
      bad++; $display("FAIL flush_clear act=%b/%0d/%0d/%b exp=0/0/0/0", ack, level, stream_idx, full);
    end
    total++; if ({overflow, underrun_cnt} !== {1'b0, 16'd0}) begin
      bad++; $display("FAIL flush_status act=%b/%0d exp=0/0", overflow, underrun_cnt);
    end
    tick();
    tick();
    total++; if ({ack, level} !== {1'b0, 6'd0}) begin
      bad++; $display("FAIL flush_discard act=%b/%0d exp=0/0", ack, level);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr_en = 1'b1; wr_data = 16'hAAAA;
    tick();
    wr_data = 16'h5555;
    tick();
    wr_en = 1'b0;
    total++; if ({ack, data_out} !== {1'b1, 16'hAAAA}) begin
      bad++; $display("FAIL areset_pre act=%b/%h exp=1/aaaa", ack, data_out);
    end
    #2 rst = 1'b0;
    #1;
    total++; if ({ack, data_out, level, full, stream_idx} !== {1'b0, 16'h0, 6'd0, 1'b0, 4'd0}) begin
      bad++; $display("FAIL areset_now act=%b/%h/%0d/%b/%0d exp=0/0000/0/0/0", ack, data_out, level, full, stream_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    tick();
    total++; if ({ack, level} !== {1'b0, 6'd0}) begin
      bad++; $display("FAIL areset_discard act=%b/%0d exp=0/0", ack, level);
    end
    wr_en = 1'b1; wr_data = 16'h0777;
    tick();
    wr_en = 1'b0;
    tick();
    total++; if ({ack, data_out} !== {1'b1, 16'h0777}) begin
      bad++; $display("FAIL areset_new act=%b/%h exp=1/0777", ack, data_out);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; req = 1'b0;
    test_reset();
    test_single();
    test_fill_and_drain();
    test_back_to_back_streams();
    test_underrun();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
